// File: rtl/alu_chunked_addsub_if.sv
// Operand/result handshake bundle for the chunked Y86-64 ALU.
// The master side presents operations and consumes results; the slave side is the ALU.
interface alu_chunked_addsub_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zf, sf, of
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zf, sf, of
  );
endinterface

// File: rtl/alu_chunked_addsub.sv
// Multi-cycle Y86-64 execute ALU: add/sub ripple CHUNK bits per clock with a registered
// carry between beats; AND/XOR share the same beat sequence. Produces ZF/SF/OF.
module alu_chunked_addsub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_chunked_addsub_if.slave   bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] chunk;
  logic             chunk_zero;
  logic             ovf;
  logic             last_beat;
  logic [WIDTH-1:0] merged;

  assign shamt      = 32'(beat_q) * 32'(CHUNK);
  assign a_ch       = CHUNK'(a_q >> shamt);
  assign b_ch       = CHUNK'(b_q >> shamt);
  assign b_eff      = (op_q == 2'b01) ? ~b_ch : b_ch;
  assign sum        = {1'b0, a_ch} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
  assign chunk_zero = (chunk == {CHUNK{1'b0}});
  assign last_beat  = (beat_q == CW'(N - 1));
  // Signed overflow: operands agree in sign but the sum does not (carry-in ^ carry-out of MSB).
  assign ovf        = (a_ch[CHUNK-1] == b_eff[CHUNK-1]) & (sum[CHUNK-1] != a_ch[CHUNK-1]);
  assign merged     = (result_q & ~(WIDTH'({CHUNK{1'b1}}) << shamt)) | (WIDTH'(chunk) << shamt);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.of        = of_q;

  // Per-beat chunk value for the latched operation
  always_comb begin
    chunk = {CHUNK{1'b0}};
    case (op_q)
      2'b00:   chunk = sum[CHUNK-1:0];
      2'b01:   chunk = sum[CHUNK-1:0];
      2'b10:   chunk = a_ch & b_ch;
      2'b11:   chunk = a_ch ^ b_ch;
      default: chunk = {CHUNK{1'b0}};
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          beat_d  = {CW{1'b0}};
          carry_d = (bus.op == 2'b01);
          zacc_d  = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        result_d = merged;
        carry_d  = sum[CHUNK];
        zacc_d   = zacc_q & chunk_zero;
        beat_d   = beat_q + CW'(1);
        if (last_beat) begin
          zf_d    = zacc_q & chunk_zero;
          sf_d    = chunk[CHUNK-1];
          of_d    = ~op_q[1] & ovf;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= {CW{1'b0}};
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      op_q     <= 2'b00;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
    end
  end
endmodule

// File: tb/tb_alu_chunked_addsub.sv
// Bench for alu_chunked_addsub: a transaction-level reference model checked every cycle,
// plus literal expectations for the corner cases (64/16 and 8/8 instances).
module tb_alu_chunked_addsub;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_chunked_addsub_if #(.WIDTH(64)) bus ();
  alu_chunked_addsub_if #(.WIDTH(8))  sbus ();

  alu_chunked_addsub #(.WIDTH(64), .CHUNK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  alu_chunked_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: whole-word signed arithmetic; returns {result, zf, sf, of}
  function automatic logic [66:0] ref_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic        o;
    case (op)
      2'd0:    begin r = a + b; o = (a[63] == b[63]) && (r[63] != a[63]); end
      2'd1:    begin r = a - b; o = (a[63] != b[63]) && (r[63] != a[63]); end
      2'd2:    begin r = a & b; o = 1'b0; end
      default: begin r = a ^ b; o = 1'b0; end
    endcase
    return {r, (r == 64'd0), r[63], o};
  endfunction

  // Transaction model: in flight for N beats, then presents result until consumed
  bit          m_busy = 1'b0;
  int          m_cyc = 0;
  logic [63:0] m_exp_res = 64'd0, m_cur_res = 64'd0;
  logic [2:0]  m_exp_fl = 3'd0, m_cur_fl = 3'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_cyc     <= 0;
      m_cur_res <= 64'd0;
      m_cur_fl  <= 3'd0;
    end else if (m_busy) begin
      if (m_cyc >= N) begin
        if (bus.out_ready) m_busy <= 1'b0;
      end else begin
        m_cyc <= m_cyc + 1;
        if (m_cyc + 1 == N) begin
          m_cur_res <= m_exp_res;
          m_cur_fl  <= m_exp_fl;
        end
      end
    end else if (bus.in_valid) begin
      {m_exp_res, m_exp_fl} <= ref_op(bus.op, bus.a, bus.b);
      m_busy <= 1'b1;
      m_cyc  <= 0;
    end
  end

  always @(negedge clk) begin
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, !m_busy});
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, (m_busy && m_cyc >= N)});
    if (!m_busy || m_cyc >= N) begin
      check("result", bus.result, m_cur_res);
      check("flags", {61'd0, bus.zf, bus.sf, bus.of}, {61'd0, m_cur_fl});
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
    check("latency", 64'(t), 64'(N));
  endtask

  task automatic finish_op(input int stall);
    repeat (stall) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a         = {$urandom, $urandom};
      bus.b         = {$urandom, $urandom};
      bus.op        = 2'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic small_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [2:0] ef);
    int t;
    sbus.op = op; sbus.a = a; sbus.b = b; sbus.in_valid = 1'b1;
    check("w8_ready", {63'd0, sbus.in_ready}, 64'd1);
    @(posedge clk); #1;
    sbus.in_valid = 1'b0;
    t = 0;
    while (!sbus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
    check("w8_latency", 64'(t), 64'd1);
    check("w8_result", {56'd0, sbus.result}, {56'd0, er});
    check("w8_flags", {61'd0, sbus.zf, sbus.sf, sbus.of}, {61'd0, ef});
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] saved_res;
    logic [2:0]  saved_fl;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.op = 2'd0; bus.a = 64'd0; bus.b = 64'd0; bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0; sbus.op = 2'd0; sbus.a = 8'd0; sbus.b = 8'd0; sbus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_flags", {61'd0, bus.zf, bus.sf, bus.of}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'd1, 64'd5, 64'd7);
    check("sub5_7", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub5_7_fl", {61'd0, bus.zf, bus.sf, bus.of}, 64'b010);
    finish_op(0);

    do_op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("add_ovf", bus.result, 64'h8000_0000_0000_0000);
    check("add_ovf_fl", {61'd0, bus.zf, bus.sf, bus.of}, 64'b011);
    finish_op(0);

    do_op(2'd1, 64'h8000_0000_0000_0000, 64'd1);
    check("sub_ovf", bus.result, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_ovf_fl", {61'd0, bus.zf, bus.sf, bus.of}, 64'b001);
    finish_op(0);

    do_op(2'd0, 64'h0000_0000_FFFF_FFFF, 64'd1);
    check("add_carry", bus.result, 64'h0000_0001_0000_0000);
    check("add_carry_fl", {61'd0, bus.zf, bus.sf, bus.of}, 64'b000);
    finish_op(0);

    do_op(2'd3, 64'h1234, 64'h1234);
    check("xor_zero", bus.result, 64'd0);
    check("xor_zero_fl", {61'd0, bus.zf, bus.sf, bus.of}, 64'b100);
    finish_op(0);

    do_op(2'd2, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
    check("and", bus.result, 64'h0F0F_0000_0F0F_0000);
    finish_op(0);

    do_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("add_wrap", bus.result, 64'd0);
    check("add_wrap_fl", {61'd0, bus.zf, bus.sf, bus.of}, 64'b100);
    finish_op(0);

    // Backpressure: result held, no accept while consumer stalls
    do_op(2'd1, 64'd100, 64'd58);
    saved_res = bus.result;
    saved_fl  = {bus.zf, bus.sf, bus.of};
    check("bp_value", saved_res, 64'd42);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    check("bp_result_held", bus.result, saved_res);
    check("bp_flags_held", {61'd0, bus.zf, bus.sf, bus.of}, {61'd0, saved_fl});
    check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    check("bp_not_cleared", bus.result, saved_res);

    // Reset two edges after an accept
    bus.op = 2'd0; bus.a = 64'h1111; bus.b = 64'h2222; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mid_rst_result", bus.result, 64'd0);
    check("mid_rst_flags", {61'd0, bus.zf, bus.sf, bus.of}, 64'd0);
    check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'd0, 64'd3, 64'd4);
    check("post_rst_add", bus.result, 64'd7);
    finish_op(0);

    small_op(2'd0, 8'd3, 8'd4, 8'd7, 3'b000);
    small_op(2'd0, 8'h7F, 8'h01, 8'h80, 3'b011);
    small_op(2'd1, 8'h05, 8'h05, 8'h00, 3'b100);
    small_op(2'd1, 8'h80, 8'h01, 8'h7F, 3'b001);

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), pick_operand(), pick_operand());
      finish_op($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
